dsp_mac_sequencer: RTL and testbench
====================================

// Module: dsp_mac_sequencer
// PURPOSE
//  Runs one dot-product job on the DSP slice: sum of in_a[i]*in_b[i], i=0..len-1.
//  Takes the operand pairs over a valid/ready stream.
//  Drives the slice clock enables (A/B, M, P) and the OPMODE word.
//  Returns the final P value over a valid/ready result port.
//  Slice pipeline is fixed: A/B reg (1), M reg (1), P reg (1); OPMODE is unregistered.
// PARAMETERS
//  A_W    18  operand A width (signed)
//  B_W    18  operand B width (signed)
//  P_W    48  slice P / result width
//  LEN_W  10  job-length field width (max len = 2^LEN_W-1)
// PORTS
//  clk           in   1      single clock; all state changes on posedge
//  rst           in   1      synchronous, active-high reset
//  start         in   1      job request; sampled only in IDLE
//  len           in   LEN_W  pair count of the job, sampled with start
//  busy          out  1      high in every state except IDLE
//  in_valid      in   1      operand pair valid
//  in_ready      out  1      high only in RUN
//  in_a          in   A_W    operand A
//  in_b          in   B_W    operand B
//  dsp_a         out  A_W    = in_a (combinational pass-through)
//  dsp_b         out  B_W    = in_b (combinational pass-through)
//  dsp_cea       out  1      A-register enable
//  dsp_ceb       out  1      B-register enable
//  dsp_cem       out  1      M-register enable
//  dsp_cep       out  1      P-register enable
//  dsp_opmode    out  8      slice OPMODE
//  dsp_p         in   P_W    slice P output
//  result_valid  out  1      result available; held until accepted
//  result_ready  in   1      result consumer ready
//  result        out  P_W    final accumulated value
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, all tag pipes=0, result=0.
//  Reset: result_valid=0, busy=0, in_ready=0, all dsp_ce*=0, dsp_opmode=8'h09.
//  Reset mid-job aborts the job; partial sums are discarded.
//  acc = in_valid & in_ready (a transfer). Tags f=first pair, l=last pair.
//  Tags travel with acc through registered stages 1,2,3: (v1,f1,l1) -> (v2,f2,l2) -> (v3,l3).
//  Slice controls:
//   - dsp_cea = dsp_ceb = acc (cycle t)
//   - dsp_cem = v1 (cycle t+1)
//   - dsp_cep = v2 (cycle t+2)
//   - dsp_opmode = (v2 & f2) ? 8'h01 : 8'h09
//     8'h01: X=M, Z=0 (first pair, clears the sum). 8'h09: X=M, Z=P (accumulate).
//  FSM states: IDLE, RUN, DRAIN, DONE.
//  IDLE:
//   - start & len!=0: load cnt=len, go to RUN.
//   - start & len==0: result=0, go to DONE.
//  RUN:
//   - on each acc, cnt decrements.
//   - f is set on the first acc of the job; l is set when cnt==1.
//   - acc with cnt==1: go to DRAIN. in_ready drops in the same cycle.
//  DRAIN:
//   - no new transfers.
//   - when v3 & l3: result <= dsp_p, go to DONE.
//   - result_valid rises 4 cycles after the last acc edge.
//  DONE:
//   - result_valid=1 and result held stable.
//   - result_ready: go to IDLE (result_valid low next cycle).
//  start outside IDLE is ignored; there is no queueing.
//  in_valid outside RUN is ignored.
//  Stalls (in_valid=0) are allowed in RUN. Bubbles flow through the tag pipe.
//  The slice holds P while cep=0.
//  Arithmetic: signed A*B, P_W-bit wrap-around. No saturation or overflow flag.
// TESTING
//  1) len=4, pairs (1,2)(3,4)(5,6)(7,8) back-to-back -> result=100.
//     Check result_valid 4 cycles after the last acc; check opmode 01,09,09,09 on the cep cycles.
//  2) len=3, pairs (-5,3)(2,-7)(4,4) with an in_valid gap of 2 cycles after the first pair -> result=-13.
//     Check cep=0 during the bubble cycles.
//  3) Two jobs in sequence (len=2 then len=1, sums 10 and 42) -> first job's P is not leaked into the second.
//     Check opmode=01 on the second job's first pair.
//  4) len=0 -> result_valid the cycle after start, result=0.
//     Check no dsp_ce* pulses.
//  5) result_ready held low 5 cycles in DONE -> result stable, busy=1, start ignored.
//     Check IDLE the cycle after the handshake.
//  6) rst asserted in RUN after 2 of 4 pairs -> next cycle all outputs at reset values.
//     A fresh len=1 (3,3) job then returns 9.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Sequencer for one dot-product job on a DSP slice with a fixed A/B, M and P
// register pipeline. It accepts operand pairs over a valid/ready stream,
// steers the slice clock enables and OPMODE from tags that travel with each
// transfer, and returns the final P value over a valid/ready result port.
module dsp_mac_sequencer #(
  parameter int A_W   = 18,
  parameter int B_W   = 18,
  parameter int P_W   = 48,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  output logic [A_W-1:0]   dsp_a,
  output logic [B_W-1:0]   dsp_b,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic [7:0]       dsp_opmode,
  input  logic [P_W-1:0]   dsp_p,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [P_W-1:0]   result
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [7:0] OPM_CLEAR = 8'h01;  // X=M, Z=0
  localparam logic [7:0] OPM_ACCUM = 8'h09;  // X=M, Z=P

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [P_W-1:0]   result_q, result_d;
  logic             acc;

  logic vld_p1_q, vld_p1_d, first_p1_q, first_p1_d, last_p1_q, last_p1_d;
  logic vld_p2_q, vld_p2_d, first_p2_q, first_p2_d, last_p2_q, last_p2_d;
  logic vld_p3_q, vld_p3_d, last_p3_q, last_p3_d;

  assign in_ready     = (state_q == RUN);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;
  assign acc          = in_valid & in_ready;

  // Operands go straight to the slice; its own A/B registers capture them.
  assign dsp_a      = in_a;
  assign dsp_b      = in_b;
  assign dsp_cea    = acc;
  assign dsp_ceb    = acc;
  assign dsp_cem    = vld_p1_q;
  assign dsp_cep    = vld_p2_q;
  assign dsp_opmode = (vld_p2_q & first_p2_q) ? OPM_CLEAR : OPM_ACCUM;

  // Tag pipe next values: each stage mirrors one slice register stage.
  always_comb begin
    // Stage 0 -> 1: tags born with the transfer (A/B register stage)
    vld_p1_d   = acc;
    first_p1_d = acc & first_q;
    last_p1_d  = acc & (cnt_q == LEN_W'(1));
    // Stage 1 -> 2: M register stage
    vld_p2_d   = vld_p1_q;
    first_p2_d = first_p1_q;
    last_p2_d  = last_p1_q;
    // Stage 2 -> 3: P register stage; first tag no longer needed
    vld_p3_d   = vld_p2_q;
    last_p3_d  = last_p2_q;
  end

  // Tag pipe registers; reset clears in-flight tags so an aborted job leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      first_p1_q <= 1'b0;
      last_p1_q  <= 1'b0;
      vld_p2_q   <= 1'b0;
      first_p2_q <= 1'b0;
      last_p2_q  <= 1'b0;
      vld_p3_q   <= 1'b0;
      last_p3_q  <= 1'b0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      first_p1_q <= first_p1_d;
      last_p1_q  <= last_p1_d;
      vld_p2_q   <= vld_p2_d;
      first_p2_q <= first_p2_d;
      last_p2_q  <= last_p2_d;
      vld_p3_q   <= vld_p3_d;
      last_p3_q  <= last_p3_d;
    end
  end

  // Job FSM next-state: counts transfers, then waits for the last tag to leave P.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            cnt_d   = len;
            first_d = 1'b1;
            state_d = RUN;
          end else begin
            result_d = '0;
            state_d  = DONE;
          end
        end
      end
      RUN: begin
        if (acc) begin
          cnt_d   = cnt_q - LEN_W'(1);
          first_d = 1'b0;
          if (cnt_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (vld_p3_q & last_p3_q) begin
          result_d = dsp_p;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a behavioural DSP slice closes the loop on
// dsp_p, and each job's result, latency and per-cycle slice controls are
// compared with values derived from the job's operand list.
module tb_dsp_mac_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_a;
  logic [17:0] in_b;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic        dsp_cea, dsp_ceb, dsp_cem, dsp_cep;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p;
  logic        result_valid;
  logic        result_ready;
  logic [47:0] result;

  dsp_mac_sequencer #(.A_W(18), .B_W(18), .P_W(48), .LEN_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb),
    .dsp_cem(dsp_cem), .dsp_cep(dsp_cep), .dsp_opmode(dsp_opmode), .dsp_p(dsp_p),
    .result_valid(result_valid), .result_ready(result_ready), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slice: A/B reg, M reg, P reg, OPMODE applied combinationally at P.
  logic signed [17:0] a_r, b_r;
  logic signed [35:0] m_r;
  logic        [47:0] p_r;
  always @(posedge clk) begin
    if (dsp_cea) a_r <= dsp_a;
    if (dsp_ceb) b_r <= dsp_b;
    if (dsp_cem) m_r <= a_r * b_r;
    if (dsp_cep) p_r <= (dsp_opmode == 8'h01) ? {{12{m_r[35]}}, m_r}
                                              : p_r + {{12{m_r[35]}}, m_r};
  end
  assign dsp_p = p_r;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, expv);
    end
  endtask

  longint qa[16];
  longint qb[16];

  // Observation state shared by the stepping task.
  int          cyc = 0;
  int          last_cyc = 0;
  int          job_len = 0;
  int          job_acc = 0;
  bit          exp_ir = 0;
  bit          acc_h1 = 0, acc_h2 = 0, f_h1 = 0, f_h2 = 0;
  bit          last_was_acc = 0;
  logic        s_rv, s_busy;
  logic [47:0] s_res;

  function automatic longint rnd18();
    logic signed [17:0] r;
    r = 18'($urandom);
    return longint'(r);
  endfunction

  // One clock: sample at negedge, check the slice controls against the
  // transfer history, then move just past the next posedge.
  task automatic step();
    bit a;
    @(negedge clk);
    cyc++;
    a = in_valid & in_ready;
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    chk("cea", 64'(dsp_cea), 64'(a));
    chk("ceb", 64'(dsp_ceb), 64'(a));
    chk("cem", 64'(dsp_cem), 64'(acc_h1));
    chk("cep", 64'(dsp_cep), 64'(acc_h2));
    chk("opmode", 64'(dsp_opmode), (acc_h2 && f_h2) ? 64'h01 : 64'h09);
    s_rv   = result_valid;
    s_res  = result;
    s_busy = busy;
    acc_h2 = acc_h1;
    f_h2   = f_h1;
    acc_h1 = a;
    f_h1   = a && (job_acc == 0);
    last_was_acc = a;
    if (a) begin
      job_acc++;
      if (job_acc == job_len) begin
        last_cyc = cyc;
        exp_ir   = 0;
      end
    end
    if (rst) begin
      acc_h1 = 0; acc_h2 = 0; f_h1 = 0; f_h2 = 0;
      exp_ir = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Run one job of n pairs from qa/qb; stall_pct random stall rate, gap1
  // forced bubbles after the first pair, hold cycles of result_ready low.
  task automatic run_job(input int n, input int stall_pct, input int gap1, input int hold);
    longint      sum;
    logic [47:0] expv;
    int          idx, guard, gaps, lat_exp;
    sum = 0;
    for (int i = 0; i < n; i++) sum += qa[i] * qb[i];
    expv    = sum[47:0];
    job_len = n;
    job_acc = 0;
    start   = 1'b1;
    len     = 10'(n);
    step();
    start   = 1'b0;
    len     = 10'($urandom);
    exp_ir  = (n != 0);
    if (n == 0) begin
      lat_exp  = 1;
      last_cyc = cyc;
    end else begin
      lat_exp = 4;
    end
    idx = 0; guard = 0; gaps = gap1;
    while (idx < n && guard < 2000) begin
      if (idx == 1 && gaps > 0) begin
        in_valid = 1'b0;
        gaps--;
      end else begin
        in_valid = ($urandom_range(0, 99) >= stall_pct);
      end
      in_a = in_valid ? qa[idx][17:0] : 18'($urandom);
      in_b = in_valid ? qb[idx][17:0] : 18'($urandom);
      step();
      guard++;
      if (last_was_acc) idx++;
    end
    if (idx < n) chk("feed_timeout", 64'(idx), 64'(n));
    guard = 0;
    while (!s_rv && guard < 30) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = 18'($urandom);
      in_b = 18'($urandom);
      step();
      guard++;
    end
    in_valid = 1'b0;
    chk("rv_latency", s_rv ? 64'(cyc - last_cyc) : 64'hdead, 64'(lat_exp));
    chk("result", 64'(s_res), 64'(expv));
    chk("busy_done", 64'(s_busy), 64'd1);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      len   = 10'($urandom_range(1, 5));
      step();
      chk("rv_hold", 64'(s_rv), 64'd1);
      chk("res_hold", 64'(s_res), 64'(expv));
      chk("busy_hold", 64'(s_busy), 64'd1);
    end
    start = 1'b0;
    result_ready = 1'b1;
    step();
    chk("rv_handshake", 64'(s_rv), 64'd1);
    result_ready = 1'b0;
    step();
    chk("rv_after", 64'(s_rv), 64'd0);
    chk("busy_after", 64'(s_busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int fed, guard, n;
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; result_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_rv", 64'(s_rv), 64'd0);
    chk("rst_result", 64'(s_res), 64'd0);

    // Back-to-back len=4 -> 100
    qa[0] = 1; qb[0] = 2; qa[1] = 3; qb[1] = 4;
    qa[2] = 5; qb[2] = 6; qa[3] = 7; qb[3] = 8;
    run_job(4, 0, 0, 0);

    // Signed pairs with a 2-cycle bubble after the first -> -13
    qa[0] = -5; qb[0] = 3; qa[1] = 2; qb[1] = -7; qa[2] = 4; qb[2] = 4;
    run_job(3, 0, 2, 0);

    // Two jobs in a row: 10 then 42, second must restart the sum
    qa[0] = 1; qb[0] = 2; qa[1] = 2; qb[1] = 4;
    run_job(2, 0, 0, 0);
    qa[0] = 6; qb[0] = 7;
    run_job(1, 0, 0, 0);

    // Empty job
    run_job(0, 0, 0, 0);

    // Consumer holds off for 5 cycles
    qa[0] = 100; qb[0] = -3; qa[1] = -1000; qb[1] = -1000; qa[2] = 7; qb[2] = 9;
    run_job(3, 0, 0, 5);

    // Reset after 2 of 4 pairs
    for (int i = 0; i < 4; i++) begin qa[i] = i + 10; qb[i] = i + 20; end
    job_len = 4; job_acc = 0;
    start = 1'b1; len = 10'd4;
    step();
    start = 1'b0; exp_ir = 1;
    fed = 0; guard = 0;
    while (fed < 2 && guard < 20) begin
      in_valid = 1'b1;
      in_a = qa[fed][17:0];
      in_b = qb[fed][17:0];
      step();
      guard++;
      if (last_was_acc) fed++;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("abort_busy", 64'(s_busy), 64'd0);
    chk("abort_rv", 64'(s_rv), 64'd0);
    chk("abort_result", 64'(s_res), 64'd0);
    qa[0] = 3; qb[0] = 3;
    run_job(1, 0, 0, 0);

    // Randomised jobs with stalls and consumer back-pressure
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        qa[i] = rnd18();
        qb[i] = rnd18();
      end
      run_job(n, 30, 0, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
